// File: rtl/pingpong_buf4_pkg.sv
// Shared widths and occupancy encodings for the two-slot ping-pong buffer.
// No logic; constants and types only.
// Imported by the interface, the buffer and anything sitting beside it.
package pingpong_buf4_pkg;

  localparam int WIDTH_DEF = 4;
  localparam int CNT_W_DEF = 8;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } occ_t;

endpackage

// File: rtl/pingpong_buf4_if.sv
// Producer/consumer bus of the ping-pong buffer, including the mux-facing outputs.
// Pure wiring, zero latency.
// Backpressure is carried by wr_ready/rd_valid inside this bundle.
interface pingpong_buf4_if
  import pingpong_buf4_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int CNT_W = CNT_W_DEF
) ();

  logic             wr_valid;
  logic [WIDTH-1:0] wr_data;
  logic             wr_ready;
  logic             rd_ready;
  logic             rd_valid;
  logic             flush;
  logic [WIDTH-1:0] slot0;
  logic [WIDTH-1:0] slot1;
  logic             sel;
  logic [1:0]       count;
  logic [CNT_W-1:0] xfer_cnt;

  modport master (
    output wr_valid, wr_data, rd_ready, flush,
    input  wr_ready, rd_valid, slot0, slot1, sel, count, xfer_cnt
  );

  modport slave (
    input  wr_valid, wr_data, rd_ready, flush,
    output wr_ready, rd_valid, slot0, slot1, sel, count, xfer_cnt
  );

endinterface

// File: rtl/mux2_4bit.sv
// Existing 4-bit 2:1 mux placed beside the buffer; S=0 picks in0, S=1 picks in1.
// Purely combinational, zero latency.
// No flow control.
module mux2_4bit (
  input  logic [3:0] in0,
  input  logic [3:0] in1,
  input  logic       S,
  output logic [3:0] res
);

  assign res = S ? in1 : in0;

endmodule

// File: rtl/pingpong_buf4.sv
// Two-slot ping-pong buffer feeding a 2:1 mux; sel always points at the oldest unread slot.
// A word written at edge N is readable after edge N; no write-to-read bypass.
// wr_ready/rd_valid come from registered occupancy only; a read at full frees space next cycle.
module pingpong_buf4
  import pingpong_buf4_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic           clk,
  input  logic           rst_n,
  pingpong_buf4_if.slave bus
);

  logic [WIDTH-1:0] slot_q [2];
  logic             wr_ptr_q;
  logic             rd_ptr_q;
  logic [1:0]       count_q;
  logic [CNT_W-1:0] xfer_q;

  logic wr_rdy;
  logic rd_vld;
  logic wr_fire;
  logic rd_fire;

  // Handshake outputs depend on state only, never on same-cycle valid/ready.
  assign wr_rdy  = (count_q != FULL);
  assign rd_vld  = (count_q != EMPTY);
  assign wr_fire = bus.wr_valid & wr_rdy;
  assign rd_fire = bus.rd_ready & rd_vld;

  assign bus.wr_ready = wr_rdy;
  assign bus.rd_valid = rd_vld;
  assign bus.slot0    = slot_q[0];
  assign bus.slot1    = slot_q[1];
  assign bus.sel      = rd_ptr_q;
  assign bus.count    = count_q;
  assign bus.xfer_cnt = xfer_q;

  // Slot storage: only reset clears it; flush and reads leave stale words behind.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      slot_q[0] <= '0;
      slot_q[1] <= '0;
    end else if (!bus.flush && wr_fire) begin
      slot_q[wr_ptr_q] <= bus.wr_data;
    end
  end

  // Pointers, occupancy and read counter; flush drops any same-cycle transfer.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= EMPTY;
      xfer_q   <= '0;
    end else if (bus.flush) begin
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= EMPTY;
    end else begin
      if (wr_fire) begin
        wr_ptr_q <= ~wr_ptr_q;
      end
      if (rd_fire) begin
        rd_ptr_q <= ~rd_ptr_q;
        xfer_q   <= xfer_q + CNT_W'(1);
      end
      if (wr_fire && !rd_fire) begin
        count_q <= count_q + 2'd1;
      end else if (rd_fire && !wr_fire) begin
        count_q <= count_q - 2'd1;
      end
    end
  end

endmodule

// File: tb/tb_pingpong_buf4.sv
// Bench for pingpong_buf4 together with the 4-bit 2:1 mux it feeds.
// Directed vector table, two hand-written corner sequences, then random traffic vs a queue model.
// Inputs change 1ns after the rising edge; outputs are sampled at that same point.
module tb_pingpong_buf4;
  import pingpong_buf4_pkg::*;

  localparam int W = 4;
  localparam int C = 8;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] res;

  always #5 clk = ~clk;

  pingpong_buf4_if #(.WIDTH(W), .CNT_W(C)) bus ();

  pingpong_buf4 #(.WIDTH(W), .CNT_W(C)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  mux2_4bit u_mux (
    .in0 (bus.slot0),
    .in1 (bus.slot1),
    .S   (bus.sel),
    .res (res)
  );

  int n_chk  = 0;
  int n_fail = 0;

  // Reference model: a queue of unread words plus plain write/read tallies.
  logic [3:0] mq [$];
  logic [3:0] mslot [2];
  int         wcnt;
  int         rcnt;
  int         mxfer;

  typedef struct {
    logic       r;
    logic       wv;
    logic [3:0] wd;
    logic       rr;
    logic       fl;
    int         cnt;
    int         sel;
    int         s0;
    int         s1;
    int         res;
    int         xfer;
  } vec_t;

  vec_t tbl [15];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic model_step(input logic r, input logic wv, input logic [3:0] wd,
                            input logic rr, input logic fl);
    bit can_wr;
    bit can_rd;
    can_wr = (mq.size() < 2);
    can_rd = (mq.size() > 0);
    if (!r) begin
      mq.delete();
      mslot[0] = 4'h0;
      mslot[1] = 4'h0;
      wcnt     = 0;
      rcnt     = 0;
      mxfer    = 0;
    end else if (fl) begin
      mq.delete();
      wcnt = 0;
      rcnt = 0;
    end else begin
      if (can_rd && rr) begin
        void'(mq.pop_front());
        rcnt++;
        mxfer = (mxfer + 1) % (1 << C);
      end
      if (can_wr && wv) begin
        mq.push_back(wd);
        mslot[wcnt % 2] = wd;
        wcnt++;
      end
    end
  endtask

  task automatic drive(input logic r, input logic wv, input logic [3:0] wd,
                       input logic rr, input logic fl);
    rst_n        = r;
    bus.wr_valid = wv;
    bus.wr_data  = wd;
    bus.rd_ready = rr;
    bus.flush    = fl;
    @(posedge clk);
    model_step(r, wv, wd, rr, fl);
    #1;
  endtask

  task automatic check_model(input string tag);
    int sz;
    sz = mq.size();
    chk({tag, " count"},    32'(bus.count),    32'(sz));
    chk({tag, " rd_valid"}, 32'(bus.rd_valid), 32'(sz != 0));
    chk({tag, " wr_ready"}, 32'(bus.wr_ready), 32'(sz != 2));
    chk({tag, " sel"},      32'(bus.sel),      32'(rcnt % 2));
    chk({tag, " slot0"},    32'(bus.slot0),    32'(mslot[0]));
    chk({tag, " slot1"},    32'(bus.slot1),    32'(mslot[1]));
    chk({tag, " xfer_cnt"}, 32'(bus.xfer_cnt), 32'(mxfer));
    if (sz > 0) chk({tag, " res"}, 32'(res), 32'(mq[0]));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    //           r     wv    wd    rr    fl    cnt sel s0   s1   res  xfer
    tbl[0]  = '{1'b0, 1'b1, 4'h7, 1'b0, 1'b0, 0,  0,  0,   0,   0,   0};
    tbl[1]  = '{1'b0, 1'b1, 4'h7, 1'b0, 1'b0, 0,  0,  0,   0,   0,   0};
    tbl[2]  = '{1'b1, 1'b1, 4'hA, 1'b0, 1'b0, 1,  0,  10,  0,   10,  0};
    tbl[3]  = '{1'b1, 1'b1, 4'h5, 1'b0, 1'b0, 2,  0,  10,  5,   10,  0};
    tbl[4]  = '{1'b1, 1'b1, 4'hF, 1'b0, 1'b0, 2,  0,  10,  5,   10,  0};
    tbl[5]  = '{1'b1, 1'b0, 4'h0, 1'b1, 1'b0, 1,  1,  10,  5,   5,   1};
    tbl[6]  = '{1'b1, 1'b0, 4'h0, 1'b1, 1'b0, 0,  0,  10,  5,   10,  2};
    tbl[7]  = '{1'b1, 1'b0, 4'h0, 1'b1, 1'b0, 0,  0,  10,  5,   10,  2};
    tbl[8]  = '{1'b1, 1'b1, 4'h3, 1'b0, 1'b0, 1,  0,  3,   5,   3,   2};
    tbl[9]  = '{1'b1, 1'b1, 4'h4, 1'b1, 1'b0, 1,  1,  3,   4,   4,   3};
    tbl[10] = '{1'b1, 1'b1, 4'h6, 1'b1, 1'b0, 1,  0,  6,   4,   6,   4};
    tbl[11] = '{1'b1, 1'b1, 4'h8, 1'b1, 1'b0, 1,  1,  6,   8,   8,   5};
    tbl[12] = '{1'b1, 1'b1, 4'h9, 1'b0, 1'b0, 2,  1,  9,   8,   8,   5};
    tbl[13] = '{1'b1, 1'b1, 4'hC, 1'b1, 1'b1, 0,  0,  9,   8,   9,   5};
    tbl[14] = '{1'b1, 1'b1, 4'h2, 1'b0, 1'b0, 1,  0,  2,   8,   2,   5};

    rst_n        = 1'b0;
    bus.wr_valid = 1'b0;
    bus.wr_data  = 4'h0;
    bus.rd_ready = 1'b0;
    bus.flush    = 1'b0;

    // Directed table: reset, fill, blocked write, drain, stream, flush collision.
    for (int i = 0; i < 15; i++) begin
      string t;
      t = $sformatf("vec%0d", i);
      drive(tbl[i].r, tbl[i].wv, tbl[i].wd, tbl[i].rr, tbl[i].fl);
      chk({t, " count"},    32'(bus.count),    32'(tbl[i].cnt));
      chk({t, " rd_valid"}, 32'(bus.rd_valid), 32'(tbl[i].cnt != 0));
      chk({t, " wr_ready"}, 32'(bus.wr_ready), 32'(tbl[i].cnt != 2));
      chk({t, " sel"},      32'(bus.sel),      32'(tbl[i].sel));
      chk({t, " slot0"},    32'(bus.slot0),    32'(tbl[i].s0));
      chk({t, " slot1"},    32'(bus.slot1),    32'(tbl[i].s1));
      chk({t, " res"},      32'(res),          32'(tbl[i].res));
      chk({t, " xfer_cnt"}, 32'(bus.xfer_cnt), 32'(tbl[i].xfer));
    end

    // Counter wrap: fresh reset, then 257 reads with one word always in flight.
    drive(1'b0, 1'b0, 4'h0, 1'b0, 1'b0);
    drive(1'b1, 1'b1, 4'h1, 1'b0, 1'b0);
    for (int i = 0; i < 257; i++) begin
      drive(1'b1, 1'b1, 4'(i + 2), 1'b1, 1'b0);
      check_model($sformatf("wrap%0d", i));
    end
    chk("wrap xfer_cnt final", 32'(bus.xfer_cnt), 32'd1);
    chk("wrap count final",    32'(bus.count),    32'd1);

    // Reset with one word held and traffic presented in the same cycle.
    drive(1'b0, 1'b1, 4'hE, 1'b1, 1'b1);
    chk("midrst count",    32'(bus.count),    32'd0);
    chk("midrst sel",      32'(bus.sel),      32'd0);
    chk("midrst rd_valid", 32'(bus.rd_valid), 32'd0);
    chk("midrst wr_ready", 32'(bus.wr_ready), 32'd1);
    chk("midrst slot0",    32'(bus.slot0),    32'd0);
    chk("midrst slot1",    32'(bus.slot1),    32'd0);
    chk("midrst xfer_cnt", 32'(bus.xfer_cnt), 32'd0);

    // Random traffic with occasional flush and reset.
    for (int i = 0; i < 2000; i++) begin
      logic r, wv, rr, fl;
      logic [3:0] wd;
      r  = ($urandom_range(0, 149) != 0);
      fl = ($urandom_range(0, 24) == 0);
      wv = ($urandom_range(0, 2) != 0);
      rr = ($urandom_range(0, 2) != 0);
      wd = 4'($urandom);
      drive(r, wv, wd, rr, fl);
      check_model($sformatf("rnd%0d", i));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/pingpong_buf4.md
Name: pingpong_buf4

Overview:
- Two-entry ping-pong buffer that directly feeds the team's 4-bit 2:1 mux.
- Holds 4-bit words in two slots and drives them onto the mux data inputs (slot0 -> in0, slot1 -> in1).
- Generates the mux select so the mux output always presents the oldest unread word.
- Producer side and consumer side each use a valid/ready handshake.

Parameters:
- WIDTH, 4, data width of each slot; must equal the mux data width.
- CNT_W, 8, width of the completed-read counter.

Ports:
- clk  input  1  system clock; all state updates on rising edge
- rst_n  input  1  synchronous active-low reset
- wr_valid  input  1  producer presents wr_data
- wr_data  input  WIDTH  word to store
- wr_ready  output  1  buffer can accept a word this cycle
- rd_ready  input  1  consumer takes the mux output this cycle
- rd_valid  output  1  mux output holds a valid unread word
- flush  input  1  synchronous discard of all stored words
- slot0  output  WIDTH  slot 0 contents, wired to mux in0
- slot1  output  WIDTH  slot 1 contents, wired to mux in1
- sel  output  1  mux select; 0 selects slot0, 1 selects slot1
- count  output  2  occupancy, 0..2
- xfer_cnt  output  CNT_W  number of completed reads

Behaviour:
- Interface: one clock; reset is synchronous and active-low. Ports are clk and rst_n.
- Reset:
  - When rst_n=0 at a rising edge: slot0=0, slot1=0, wr_ptr=0, rd_ptr=0, count=0, xfer_cnt=0.
  - Outputs after reset: sel=0, rd_valid=0, wr_ready=1.
  - Reset overrides flush, writes and reads in the same cycle.
  - Reset mid-transfer discards all data; no partial state survives.
- Internal state: 1-bit wr_ptr, 1-bit rd_ptr, 2-bit count. sel equals rd_ptr (registered, no combinational path from inputs).
- Handshake outputs are combinational from state only:
  - wr_ready = (count != 2)
  - rd_valid = (count != 0)
  - Neither depends on wr_valid or rd_ready in the same cycle.
- Write accept (wr_valid & wr_ready): wr_data is stored into slot[wr_ptr], then wr_ptr toggles.
- Read accept (rd_valid & rd_ready): rd_ptr toggles and xfer_cnt increments. xfer_cnt wraps from 2^CNT_W-1 to 0; there is no saturation.
- Count update:
  - +1 on write only, -1 on read only.
  - Unchanged on simultaneous write and read (legal only when count=1; at count=2 no write, at count=0 no read).
- Latency:
  - A word written at edge N is visible on its slot output and as rd_valid after edge N.
  - There is no bypass: with count=0 the word cannot be read in the same cycle it is written.
- Full (count=2): wr_ready=0. A read in that cycle frees a slot, but wr_ready rises only in the next cycle.
- Empty (count=0): rd_valid=0. rd_ready is ignored.
- Slot data is never cleared except by reset. Slot outputs keep stale values after reads; consumers must qualify with rd_valid.
- Pointer wrap: pointers toggle 0->1->0, so ordering is strict FIFO across unlimited transfers.
- Flush (rst_n=1, flush=1):
  - wr_ptr=0, rd_ptr=0, count=0.
  - Slot contents and xfer_cnt are unchanged.
  - A simultaneous write or read is discarded and not counted.
- Values of inputs while wr_valid=0 are don't-care. Holding wr_valid with changing wr_data while wr_ready=0 has no effect.

Decomposition:
- Shared package: WIDTH default, CNT_W default, and count encodings EMPTY=2'd0, ONE=2'd1, FULL=2'd2.
- No sub-module inside the block. The existing 4-bit 2:1 mux is instantiated alongside it at the next level up, connected as in0=slot0, in1=slot1, S=sel.
- The bench instantiates both and checks the mux res against its reference model.

Test Plan:
- Reset: rst_n=0 for 2 cycles with wr_valid=1 -> count=0, sel=0, rd_valid=0, wr_ready=1, slot0=slot1=0, xfer_cnt=0.
- Fill to full: write 4'hA, then 4'h5 with rd_ready=0 -> slot0=A, slot1=5, count=2, wr_ready=0, sel=0, mux res=A. A third write of 4'hF is not accepted and slots are unchanged.
- Drain in order: from full {A,5}, rd_ready=1 for 2 cycles -> res A then 5; sel 0->1->0; count 2->1->0; rd_valid=0 after; xfer_cnt=2.
- Simultaneous steady stream: count=1 holding 4'h3, then each cycle write 4'h4, 4'h6, 4'h8 with rd_ready=1 -> res sequence 3,4,6,8; count stays 1; pointers alternate.
- Flush with collision: count=2, then flush=1 with wr_valid=1 (4'hC) and rd_ready=1 in the same cycle -> count=0, sel=0, xfer_cnt unchanged, slots unchanged (no C stored).
- Counter wrap: CNT_W=8, perform 257 reads -> xfer_cnt=1. Also apply rst_n=0 mid-stream with count=1 -> everything returns to reset values on the next edge.
